// File: rtl/down_counter_with_loading.sv
// Purpose: loadable down counter with IDLE/RUN/DONE FSM and registered terminal-count pulse.
// Latency: one cycle from load_i (or decrement) edge to count_o; tc_o is registered alongside count_o.
// Backpressure: none; load_i/en_i are sampled every rising edge and always accepted.
//
// Ports:
//   clk         single clock, all state updates on the rising edge
//   reset       synchronous active-high reset (priority over load_i and en_i)
//   load_i      load strobe; load_val_i goes to count_o (and reload register) next cycle
//   load_val_i  value to load
//   en_i        count enable, only honoured in RUN
//   count_o     registered current count
//   tc_o        registered one-cycle terminal-count pulse
//   busy_o      high while the FSM is in RUN
//   zero_o      combinational flag, count_o == 0
//
// Build option: define DOWN_COUNTER_AUTO_RELOAD_EN to make RUN reload from the
// captured load value instead of stopping at zero (periodic mode).
module down_counter_with_loading #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_i,
  input  logic [WIDTH-1:0] load_val_i,
  input  logic             en_i,
  output logic [WIDTH-1:0] count_o,
  output logic             tc_o,
  output logic             busy_o,
  output logic             zero_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic             tc_q, tc_d;
`ifdef DOWN_COUNTER_AUTO_RELOAD_EN
  logic [WIDTH-1:0] reload_q, reload_d;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      count_q  <= '0;
      tc_q     <= 1'b0;
`ifdef DOWN_COUNTER_AUTO_RELOAD_EN
      reload_q <= '0;
`endif
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      tc_q     <= tc_d;
`ifdef DOWN_COUNTER_AUTO_RELOAD_EN
      reload_q <= reload_d;
`endif
    end
  end

  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    tc_d     = 1'b0;
`ifdef DOWN_COUNTER_AUTO_RELOAD_EN
    reload_d = reload_q;
`endif

    if (load_i) begin
      // Load beats enable/decrement in every state, and suppresses any tc
      // that would have fired on this edge.
      count_d = load_val_i;
`ifdef DOWN_COUNTER_AUTO_RELOAD_EN
      reload_d = load_val_i;
`endif
      state_d = (load_val_i != '0) ? RUN : DONE;
    end else begin
      unique case (state_q)
        IDLE: begin
          count_d = '0;
        end
        RUN: begin
          if (count_q == '0) begin
            // Unreachable through loads; recover to a consistent state.
            state_d = DONE;
          end else if (en_i) begin
            if (count_q == WIDTH'(1)) begin
              tc_d = 1'b1;
`ifdef DOWN_COUNTER_AUTO_RELOAD_EN
              // Skip zero: jump straight back to the reload value so the
              // period equals the loaded value in enabled cycles.
              count_d = reload_q;
              state_d = RUN;
`else
              count_d = '0;
              state_d = DONE;
`endif
            end else begin
              count_d = count_q - WIDTH'(1);
            end
          end
        end
        DONE: begin
          count_d = '0;
        end
        default: begin
          state_d = IDLE;
          count_d = '0;
        end
      endcase
    end
  end

  assign count_o = count_q;
  assign tc_o    = tc_q;
  assign busy_o  = (state_q == RUN);
  assign zero_o  = (count_q == '0);

endmodule
